// File: rtl/dnn_infer_seq_if.sv
// Host request/result channel and engine control bundle for dnn_infer_seq.
// The sequencer uses the slave modport; the host/engine side uses master.
interface dnn_infer_seq_if #(
  parameter int DATA_WIDTH = 14,
  parameter int IDX_WIDTH  = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  res_valid;
  logic                  res_ready;
  logic [IDX_WIDTH-1:0]  res_digit;
  logic [DATA_WIDTH-1:0] res_score;
  logic                  res_timeout;
  logic                  busy;
  logic                  eng_start;
  logic                  eng_reset;
  logic                  eng_done;
  logic [IDX_WIDTH-1:0]  eng_out_idx;
  logic [DATA_WIDTH-1:0] eng_out;

  modport slave (
    input  req_valid, res_ready, eng_done, eng_out,
    output req_ready, res_valid, res_digit, res_score, res_timeout,
           busy, eng_start, eng_reset, eng_out_idx
  );

  modport master (
    output req_valid, res_ready, eng_done, eng_out,
    input  req_ready, res_valid, res_digit, res_score, res_timeout,
           busy, eng_start, eng_reset, eng_out_idx
  );
endinterface

// File: rtl/dnn_infer_seq.sv
// Inference sequencer: clears and launches the engine, waits for done or timeout,
// then scans the output neurons for the signed argmax and reports it to the host.
module dnn_infer_seq #(
  parameter int DATA_WIDTH     = 14,
  parameter int NUM_CLASSES    = 10,
  parameter int IDX_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int TO_WIDTH       = 21
) (
  input logic          clk,
  input logic          rst,
  dnn_infer_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CLR, LAUNCH, WAIT, SCAN, REPORT} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
  localparam logic [TO_WIDTH-1:0]  TO_LAST  = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                       state, state_nx;
  logic [TO_WIDTH-1:0]          to_cnt;
  logic [IDX_WIDTH-1:0]         idx;
  logic [IDX_WIDTH-1:0]         arg, arg_nx;
  logic signed [DATA_WIDTH-1:0] maxv, max_nx, score_in;
  logic                         take, last, to_hit;
  logic [IDX_WIDTH-1:0]         res_digit_q;
  logic [DATA_WIDTH-1:0]        res_score_q;
  logic                         res_timeout_q;

  assign score_in = $signed(bus.eng_out);
  assign last     = (idx == LAST_IDX);
  assign to_hit   = (to_cnt == TO_LAST);

  // Strict compare keeps the lowest index on ties; index 0 always seeds the max.
  always_comb begin
    take   = (idx == '0) || (score_in > maxv);
    max_nx = take ? score_in : maxv;
    arg_nx = take ? idx : arg;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nx = CLR;
      CLR:     state_nx = LAUNCH;
      LAUNCH:  state_nx = WAIT;
      WAIT: begin
        if (bus.eng_done)  state_nx = SCAN;
        else if (to_hit)   state_nx = REPORT;
      end
      SCAN:    if (last) state_nx = REPORT;
      REPORT:  if (bus.res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt        <= '0;
      idx           <= '0;
      arg           <= '0;
      maxv          <= '0;
      res_digit_q   <= '0;
      res_score_q   <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      case (state)
        LAUNCH: to_cnt <= '0;
        WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          if (!bus.eng_done && to_hit) begin
            res_digit_q   <= '1;
            res_score_q   <= '0;
            res_timeout_q <= 1'b1;
          end
        end
        SCAN: begin
          maxv <= max_nx;
          arg  <= arg_nx;
          idx  <= last ? '0 : idx + 1'b1;
          if (last) begin
            res_digit_q   <= arg_nx;
            res_score_q   <= max_nx;
            res_timeout_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes decode from state so an async reset drops them immediately.
  assign bus.req_ready   = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.eng_reset   = (state == CLR);
  assign bus.eng_start   = (state == LAUNCH);
  assign bus.res_valid   = (state == REPORT);
  assign bus.eng_out_idx = idx;
  assign bus.res_digit   = res_digit_q;
  assign bus.res_score   = res_score_q;
  assign bus.res_timeout = res_timeout_q;

endmodule

// File: tb/tb_dnn_infer_seq.sv
// Directed bench for dnn_infer_seq: a main instance with the default timeout and
// a second instance with a 64-cycle timeout, sharing host stimulus.
module tb_dnn_infer_seq;
  localparam int DW = 14;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dnn_infer_seq_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus_n ();
  dnn_infer_seq_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus_t ();

  dnn_infer_seq #(.DATA_WIDTH(DW), .NUM_CLASSES(10), .IDX_WIDTH(IW)) dut_n (
    .clk(clk), .rst(rst), .bus(bus_n));

  dnn_infer_seq #(.DATA_WIDTH(DW), .NUM_CLASSES(10), .IDX_WIDTH(IW),
                  .TIMEOUT_CYCLES(64), .TO_WIDTH(7)) dut_t (
    .clk(clk), .rst(rst), .bus(bus_t));

  logic req_valid = 1'b0, res_ready = 1'b0, eng_done = 1'b0, sel = 1'b0;
  logic signed [DW-1:0] scores [10];
  int sc_tab [10];

  assign bus_n.req_valid = req_valid;
  assign bus_n.res_ready = res_ready;
  assign bus_n.eng_done  = eng_done;
  assign bus_t.req_valid = req_valid;
  assign bus_t.res_ready = res_ready;
  assign bus_t.eng_done  = eng_done;
  always_comb bus_n.eng_out = (bus_n.eng_out_idx < 4'd10) ? scores[bus_n.eng_out_idx] : '0;
  always_comb bus_t.eng_out = (bus_t.eng_out_idx < 4'd10) ? scores[bus_t.eng_out_idx] : '0;

  logic req_ready, res_valid, res_timeout, busy, eng_start, eng_reset;
  logic [IW-1:0] res_digit, eng_out_idx;
  logic signed [DW-1:0] res_score;
  always_comb begin
    req_ready   = sel ? bus_t.req_ready   : bus_n.req_ready;
    res_valid   = sel ? bus_t.res_valid   : bus_n.res_valid;
    res_timeout = sel ? bus_t.res_timeout : bus_n.res_timeout;
    busy        = sel ? bus_t.busy        : bus_n.busy;
    eng_start   = sel ? bus_t.eng_start   : bus_n.eng_start;
    eng_reset   = sel ? bus_t.eng_reset   : bus_n.eng_reset;
    res_digit   = sel ? bus_t.res_digit   : bus_n.res_digit;
    eng_out_idx = sel ? bus_t.eng_out_idx : bus_n.eng_out_idx;
    res_score   = sel ? $signed(bus_t.res_score) : $signed(bus_n.res_score);
  end

  int vec = 0, err = 0;
  int n_rst_p = 0, n_start_p = 0;
  always @(posedge clk) begin
    if (eng_reset) n_rst_p++;
    if (eng_start) n_start_p++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_scores;
    for (int i = 0; i < 10; i++) scores[i] = DW'(sc_tab[i]);
  endtask

  // stale: 0 none, 1 done high into request and dropped on eng_reset, 2 held until WAIT.
  // delay < 0 means eng_done never rises (timeout expected).
  task automatic run_infer(input string name, input int delay, input int stall,
                           input int stale, input bit preacc, input bit keep_req,
                           input int exp_d, input int exp_s, input bit exp_to);
    int n;
    bit bad;
    load_scores();
    if (!preacc) begin
      if (stale != 0) eng_done = 1'b1;
      vec++;
      if (req_ready !== 1'b1) begin
        err++; $display("FAIL %s req_ready_idle: got %b want 1", name, req_ready);
      end
      n_rst_p = 0; n_start_p = 0;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
    end else begin
      n_rst_p = 0; n_start_p = 0;
    end
    vec++;
    if ({busy, eng_reset, eng_start, req_ready} !== 4'b1100) begin
      err++; $display("FAIL %s clr: busy/rst/start/rdy got %b want 1100", name,
                      {busy, eng_reset, eng_start, req_ready});
    end
    if (stale == 1) eng_done = 1'b0;
    tick();
    vec++;
    if ({eng_reset, eng_start} !== 2'b01) begin
      err++; $display("FAIL %s launch: rst/start got %b want 01", name, {eng_reset, eng_start});
    end
    tick();
    if (delay >= 0) begin
      bad = 1'b0;
      for (int j = 0; j < delay; j++) begin
        tick();
        if (res_valid !== 1'b0 || eng_out_idx !== 4'd0 || busy !== 1'b1) bad = 1'b1;
      end
      vec++;
      if (bad) begin
        err++; $display("FAIL %s wait_hold: early exit or idx moved, got bad=%b want 0", name, bad);
      end
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      n = 0;
      while (res_valid !== 1'b1 && n < 40) begin tick(); n++; end
      vec++;
      if (n !== 10) begin
        err++; $display("FAIL %s scan_latency: got %0d edges want 10", name, n);
      end
    end else begin
      n = 0; bad = 1'b0;
      while (res_valid !== 1'b1 && n < 200) begin
        tick(); n++;
        if (eng_out_idx !== 4'd0) bad = 1'b1;
      end
      vec++;
      if (n !== 64 || bad) begin
        err++; $display("FAIL %s timeout_latency: got %0d edges idx_moved=%b want 64/0", name, n, bad);
      end
    end
    vec++;
    if (res_digit !== IW'(exp_d) || res_score !== DW'(exp_s) || res_timeout !== exp_to) begin
      err++; $display("FAIL %s result: digit/score/to got %0d/%0d/%b want %0d/%0d/%b",
                      name, res_digit, res_score, res_timeout, exp_d, exp_s, exp_to);
    end
    vec++;
    if (n_rst_p !== 1 || n_start_p !== 1) begin
      err++; $display("FAIL %s pulses: eng_reset/eng_start got %0d/%0d want 1/1", name, n_rst_p, n_start_p);
    end
    if (keep_req) req_valid = 1'b1;
    if (stall > 0) begin
      bad = 1'b0;
      req_valid = 1'b1;
      for (int j = 0; j < stall; j++) begin
        tick();
        if (res_valid !== 1'b1 || req_ready !== 1'b0 || res_digit !== IW'(exp_d) ||
            res_score !== DW'(exp_s) || res_timeout !== exp_to) bad = 1'b1;
      end
      vec++;
      if (bad) begin
        err++; $display("FAIL %s backpressure: outputs moved or req_ready high, got bad=%b want 0", name, bad);
      end
      if (!keep_req) req_valid = 1'b0;
    end
    vec++;
    if (req_ready !== 1'b0 || res_valid !== 1'b1) begin
      err++; $display("FAIL %s handshake_cycle: rdy/valid got %b%b want 01", name, req_ready, res_valid);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    vec++;
    if ({busy, res_valid, req_ready} !== 3'b001) begin
      err++; $display("FAIL %s back_to_idle: busy/valid/rdy got %b want 001", name, {busy, res_valid, req_ready});
    end
    if (keep_req) begin
      tick();
      req_valid = 1'b0;
      vec++;
      if ({busy, eng_reset} !== 2'b11) begin
        err++; $display("FAIL %s reaccept: busy/eng_reset got %b want 11", name, {busy, eng_reset});
      end
    end
  endtask

  task automatic test_reset;
    tick(); tick();
    vec++;
    if ({req_ready, res_valid, res_timeout, busy, eng_start, eng_reset, eng_out_idx, res_digit, res_score}
        !== {1'b1, 5'b0, 4'd0, 4'd0, 14'd0}) begin
      err++; $display("FAIL reset_values: rdy/valid/to/busy/start/rst=%b idx=%0d digit=%0d score=%0d want 100000/0/0/0",
                      {req_ready, res_valid, res_timeout, busy, eng_start, eng_reset}, eng_out_idx, res_digit, res_score);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_normal;
    sc_tab = '{-100, 20, 300, 5, -8191, 299, 0, 1, 2, 3};
    run_infer("normal", 500, 0, 0, 1'b0, 1'b0, 2, 300, 1'b0);
  endtask

  task automatic test_ties_negatives;
    sc_tab = '{-50, -50, -50, -50, -3, -50, -50, -3, -50, -50};
    run_infer("tie_neg", 3, 0, 0, 1'b0, 1'b0, 4, -3, 1'b0);
    sc_tab = '{-8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192};
    run_infer("all_min", 0, 0, 0, 1'b0, 1'b0, 0, -8192, 1'b0);
    sc_tab = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 8191};
    run_infer("last_idx", 7, 0, 0, 1'b0, 1'b0, 9, 8191, 1'b0);
  endtask

  task automatic test_back_to_back;
    sc_tab = '{10, 20, 30, 40, 50, 60, 70, 80, 90, -1};
    run_infer("bp_first", 12, 20, 0, 1'b0, 1'b1, 8, 90, 1'b0);
    sc_tab = '{5, -5, 5, 6, 0, 0, 6, 0, 0, 0};
    run_infer("bp_second", 4, 0, 0, 1'b1, 1'b0, 3, 6, 1'b0);
  endtask

  task automatic test_stale_done;
    sc_tab = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 77};
    run_infer("stale_drop", 30, 0, 1, 1'b0, 1'b0, 9, 77, 1'b0);
    sc_tab = '{-7, 100, -7, -7, -7, -7, -7, -7, -7, -7};
    run_infer("stale_held", 0, 0, 2, 1'b0, 1'b0, 1, 100, 1'b0);
  endtask

  task automatic test_reset_mid;
    sc_tab = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    load_scores();
    for (int ph = 0; ph < 3; ph++) begin
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      if (ph == 0) begin
        vec++;
        if (eng_start !== 1'b1) begin
          err++; $display("FAIL rst_launch_pre: eng_start got %b want 1", eng_start);
        end
      end else if (ph == 1) begin
        repeat (6) tick();
      end else begin
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        repeat (4) tick();
        vec++;
        if (eng_out_idx !== 4'd4) begin
          err++; $display("FAIL rst_scan_pre: eng_out_idx got %0d want 4", eng_out_idx);
        end
      end
      #2 rst = 1'b1;
      #1;
      vec++;
      if ({req_ready, res_valid, res_timeout, busy, eng_start, eng_reset, eng_out_idx, res_digit, res_score}
          !== {1'b1, 5'b0, 4'd0, 4'd0, 14'd0}) begin
        err++; $display("FAIL rst_mid_phase%0d: rdy/valid/to/busy/start/rst=%b idx=%0d digit=%0d score=%0d want 100000/0/0/0",
                        ph, {req_ready, res_valid, res_timeout, busy, eng_start, eng_reset},
                        eng_out_idx, res_digit, res_score);
      end
      rst = 1'b0;
      tick();
    end
    run_infer("after_rst", 9, 0, 0, 1'b0, 1'b0, 5, 9, 1'b0);
  endtask

  task automatic test_timeout;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    sel = 1'b1;
    tick();
    sc_tab = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    run_infer("timeout", -1, 3, 0, 1'b0, 1'b0, 15, 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_ties_negatives();
    test_back_to_back();
    test_stale_done();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dnn_infer_seq.md
Name: dnn_infer_seq

Overview:
Sequencer and result scanner for the 14-bit fixed-point sigmoid MNIST inference engine. It accepts one classification request per handshake, clears and launches the engine, then waits for `done` or a timeout. It then walks the engine's 10-entry output select index and computes the signed argmax, returning the predicted digit and its score to the host over a valid/ready result channel.

Parameters:
DATA_WIDTH, 14, width of engine output scores (signed fixed-point)
NUM_CLASSES, 10, number of output neurons scanned
IDX_WIDTH, 4, width of engine out_idx select
TIMEOUT_CYCLES, 1048576, max WAIT cycles before abort
TO_WIDTH, 21, timeout counter width (must hold TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  host requests one inference
req_ready  out  1  high only in IDLE
res_valid  out  1  result available, held until accepted
res_ready  in  1  host accepts result
res_digit  out  IDX_WIDTH  predicted class 0..9; 4'hF on timeout
res_score  out  DATA_WIDTH  signed max score; 0 on timeout
res_timeout  out  1  result is a timeout abort
busy  out  1  state != IDLE
eng_start  out  1  engine start, one-cycle pulse
eng_reset  out  1  engine synchronous clear, one-cycle pulse
eng_done  in  1  engine done level
eng_out_idx  out  IDX_WIDTH  engine output select
eng_out  in  DATA_WIDTH  engine selected score (combinational from eng_out_idx)

Behaviour:
- Reset values: state IDLE; all outputs 0 except req_ready=1; eng_out_idx=0; internal max/argmax/counters cleared.
- States: IDLE -> CLR -> LAUNCH -> WAIT -> SCAN -> REPORT -> IDLE.
- IDLE: req_ready=1. A request is accepted when req_valid && req_ready at edge k. CLR is entered at k+1.
- CLR: eng_reset=1 for exactly one cycle. Go to LAUNCH.
- LAUNCH: eng_start=1 for exactly one cycle. Clear timeout counter. Go to WAIT. eng_done is ignored in CLR/LAUNCH, which prevents a stale done from a prior run being accepted.
- WAIT: the timeout counter increments every cycle.
  - eng_done=1 sampled: go to SCAN with eng_out_idx=0.
  - Otherwise, counter == TIMEOUT_CYCLES-1: go to REPORT with res_timeout=1, res_digit=4'hF, res_score=0.
  - eng_done takes priority over timeout in the same cycle.
- SCAN: one class per cycle, eng_out_idx = i for i=0..NUM_CLASSES-1.
  - i=0: max<=eng_out, arg<=0.
  - i>0: if signed eng_out > max (strict), max<=eng_out, arg<=i. Ties therefore keep the lowest index.
  - After i=NUM_CLASSES-1, go to REPORT. eng_out_idx returns to 0.
- REPORT: res_valid=1; res_digit/res_score/res_timeout are stable while res_valid && !res_ready. On res_valid && res_ready, go to IDLE next cycle.
  - req_ready stays 0 during the handshake cycle, so there is no same-cycle re-acceptance.
- Latency: done sampled at edge N gives SCAN cycles N+1..N+10 and res_valid asserted from N+11. Minimum request-to-result latency is k+3 (first WAIT) plus engine time plus 11.
- Compare arithmetic: full DATA_WIDTH two's complement; no saturation or truncation.
- rst asserted mid-operation: immediate return to IDLE with reset values, and eng_start/eng_reset drop asynchronously. The engine is re-cleared via CLR on the next request.
- req_valid while busy: ignored (req_ready=0), with no queueing.

Test Plan:
- Normal: request accepted, eng_done after 500 cycles, scores {-100,20,300,5,-8191,299,0,1,2,3} -> exactly one eng_reset pulse then one eng_start pulse. res_valid 11 cycles after done with res_digit=2, res_score=300, res_timeout=0.
- Tie and negatives: scores all -50 except idx4=idx7=-3 -> res_digit=4, res_score=-3. All -8192 -> res_digit=0, res_score=-8192.
- Timeout: TIMEOUT_CYCLES=64, eng_done never rises -> res_valid at WAIT cycle 64, res_timeout=1, res_digit=4'hF, res_score=0, with no SCAN cycles.
- Backpressure: hold res_ready=0 for 20 cycles with req_valid=1 continuously -> outputs stable, req_ready=0 throughout. Second request accepted only the cycle after IDLE is re-entered.
- Stale done: eng_done held 1 from a previous run into a new request -> no early exit during CLR/LAUNCH. WAIT exits on the first WAIT cycle, since done is still high; the bench drops done in response to eng_reset to check that the correct wait occurs.
- Reset mid-WAIT and mid-SCAN: assert rst asynchronously -> all outputs at reset values immediately. A next request runs normally to the correct result.
